// File: rtl/cmd_sequencer.sv
// Layer command sequencer: fetches 6-word commands into a shadow register, validates and issues them to the engines.
// Optional watchdog on the RUN state is enabled by defining CSB_WDT_EN.
module cmd_sequencer #(
    parameter int          CNT_W     = 7,
    parameter int          WDT_W     = 20,
    parameter int unsigned WDT_LIMIT = 32'h000F_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_en,
    input  logic             irq_clr,
    input  logic [CNT_W-1:0] cmd_size,
    input  logic [31:0]      cmd,
    input  logic             cmd_we,
    output logic             cmd_rd_en,
    input  logic             engine_ready,
    output logic             engine_valid,
    output logic             engine_reset,
    output logic [2:0]       op_type,
    output logic             padding,
    output logic [3:0]       stride,
    output logic [7:0]       kernel,
    output logic [15:0]      i_channel,
    output logic [15:0]      o_channel,
    output logic [7:0]       i_side,
    output logic [7:0]       o_side,
    output logic [7:0]       kernel_size,
    output logic [7:0]       stride2,
    output logic [31:0]      weight_start_addr,
    output logic [31:0]      data_start_addr,
    output logic [31:0]      result_start_addr,
    output logic [CNT_W-1:0] done_cmd_count,
    output logic             busy,
    output logic [1:0]       err,
    output logic             irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_RUN,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t state, state_next;

    // Word 0 is kept compacted: {kernel, stride, padding, op_type}
    logic [15:0]      sh_w0;
    logic [31:0]      sh_w1, sh_w2, sh_w3, sh_w4, sh_w5;
    logic             shadow_full;
    logic [2:0]       word_idx;
    logic [CNT_W-1:0] fetched;
    logic [CNT_W-1:0] size_r;
    logic [CNT_W-1:0] done_inc;

    logic fetch_act, last_word, cmd_ok, timeout;
    logic do_start, do_issue, do_bad, do_done, do_wdt, do_clr;

    assign fetch_act = ((state == S_WAIT) || (state == S_ISSUE) || (state == S_RUN))
                       && !shadow_full && (fetched < size_r);
    assign last_word = (word_idx == 3'd5);
    assign cmd_rd_en = fetch_act && !(cmd_we && last_word);
    assign done_inc  = done_cmd_count + CNT_W'(1);
    assign cmd_ok    = ((sh_w0[2:0] == 3'b001) || (sh_w0[2:0] == 3'b100) || (sh_w0[2:0] == 3'b101))
                       && (sh_w0[7:4] != 4'd0);

`ifdef CSB_WDT_EN
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
    logic [WDT_W-1:0] wdt;

    // The counter holds the number of RUN cycles already spent on the current command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt <= '0;
        end else if (do_issue) begin
            wdt <= '0;
        end else if (state == S_RUN) begin
            wdt <= wdt + WDT_W'(1);
        end
    end

    assign timeout = (wdt == WDT_LAST);
`else
    logic [WDT_W-1:0] wdt_unused;
    assign wdt_unused = WDT_W'(WDT_LIMIT);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_issue   = 1'b0;
        do_bad     = 1'b0;
        do_done    = 1'b0;
        do_wdt     = 1'b0;
        do_clr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_en) begin
                    do_start   = 1'b1;
                    state_next = (cmd_size != '0) ? S_WAIT : S_FINISH;
                end
            end
            S_WAIT: begin
                if (shadow_full) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (cmd_ok) begin
                    do_issue   = 1'b1;
                    state_next = S_RUN;
                end else begin
                    do_bad     = 1'b1;
                    state_next = S_ERROR;
                end
            end
            S_RUN: begin
                if (engine_ready) begin
                    do_done = 1'b1;
                    if (done_inc == size_r)  state_next = S_FINISH;
                    else if (shadow_full)    state_next = S_ISSUE;
                    else                     state_next = S_WAIT;
                end else if (timeout) begin
                    do_wdt     = 1'b1;
                    state_next = S_ERROR;
                end
            end
            S_FINISH, S_ERROR: begin
                if (irq_clr) begin
                    do_clr     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            shadow_full    <= 1'b0;
            word_idx       <= 3'd0;
            fetched        <= '0;
            size_r         <= '0;
            done_cmd_count <= '0;
            engine_valid   <= 1'b0;
            engine_reset   <= 1'b1;
            busy           <= 1'b0;
            err            <= 2'b00;
            irq            <= 1'b0;
        end else begin
            state <= state_next;
            if (do_start) begin
                size_r         <= cmd_size;
                fetched        <= '0;
                word_idx       <= 3'd0;
                shadow_full    <= 1'b0;
                done_cmd_count <= '0;
                err            <= 2'b00;
                busy           <= (cmd_size != '0);
                irq            <= (cmd_size == '0);
            end
            if (fetch_act && cmd_we) begin
                if (last_word) begin
                    shadow_full <= 1'b1;
                    word_idx    <= 3'd0;
                    fetched     <= fetched + CNT_W'(1);
                end else begin
                    word_idx <= word_idx + 3'd1;
                end
            end
            if (do_issue) begin
                shadow_full  <= 1'b0;
                engine_valid <= 1'b1;
                engine_reset <= 1'b0;
            end
            if (do_bad) begin
                err  <= 2'b01;
                irq  <= 1'b1;
                busy <= 1'b0;
            end
            if (do_done) begin
                engine_valid   <= 1'b0;
                engine_reset   <= 1'b1;
                done_cmd_count <= done_inc;
                if (state_next == S_FINISH) begin
                    irq  <= 1'b1;
                    busy <= 1'b0;
                end
            end
            if (do_wdt) begin
                engine_valid <= 1'b0;
                engine_reset <= 1'b1;
                err          <= 2'b10;
                irq          <= 1'b1;
                busy         <= 1'b0;
            end
            if (do_clr) begin
                irq            <= 1'b0;
                err            <= 2'b00;
                done_cmd_count <= '0;
                fetched        <= '0;
                word_idx       <= 3'd0;
                shadow_full    <= 1'b0;
            end
        end
    end

    // Shadow words carry no reset; shadow_full alone marks them meaningful.
    always_ff @(posedge clk) begin
        if (fetch_act && cmd_we) begin
            case (word_idx)
                3'd0:    sh_w0 <= {cmd[23:16], cmd[11:8], cmd[4], cmd[2:0]};
                3'd1:    sh_w1 <= cmd;
                3'd2:    sh_w2 <= cmd;
                3'd3:    sh_w3 <= cmd;
                3'd4:    sh_w4 <= cmd;
                default: sh_w5 <= cmd;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_type           <= 3'd0;
            padding           <= 1'b0;
            stride            <= 4'd0;
            kernel            <= 8'd0;
            i_channel         <= 16'd0;
            o_channel         <= 16'd0;
            i_side            <= 8'd0;
            o_side            <= 8'd0;
            kernel_size       <= 8'd0;
            stride2           <= 8'd0;
            weight_start_addr <= 32'd0;
            data_start_addr   <= 32'd0;
            result_start_addr <= 32'd0;
        end else if (do_issue) begin
            op_type           <= sh_w0[2:0];
            padding           <= sh_w0[3];
            stride            <= sh_w0[7:4];
            kernel            <= sh_w0[15:8];
            i_channel         <= sh_w1[15:0];
            o_channel         <= sh_w1[31:16];
            i_side            <= sh_w2[7:0];
            o_side            <= sh_w2[15:8];
            kernel_size       <= sh_w2[23:16];
            stride2           <= sh_w2[31:24];
            weight_start_addr <= sh_w3;
            data_start_addr   <= sh_w4;
            result_start_addr <= sh_w5;
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: issue timing, prefetch, bad command, stray writes, mid-run reset.
module tb_cmd_sequencer;

    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_en = 1'b0;
    logic             irq_clr = 1'b0;
    logic [CNT_W-1:0] cmd_size = '0;
    logic [31:0]      cmd = '0;
    logic             cmd_we = 1'b0;
    logic             cmd_rd_en;
    logic             engine_ready = 1'b0;
    logic             engine_valid;
    logic             engine_reset;
    logic [2:0]       op_type;
    logic             padding;
    logic [3:0]       stride;
    logic [7:0]       kernel;
    logic [15:0]      i_channel;
    logic [15:0]      o_channel;
    logic [7:0]       i_side;
    logic [7:0]       o_side;
    logic [7:0]       kernel_size;
    logic [7:0]       stride2;
    logic [31:0]      weight_start_addr;
    logic [31:0]      data_start_addr;
    logic [31:0]      result_start_addr;
    logic [CNT_W-1:0] done_cmd_count;
    logic             busy;
    logic [1:0]       err;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cmd_a [6];
    logic [31:0] cmd_b [6];
    logic [31:0] cmd_c [6];

    cmd_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op_en(op_en), .irq_clr(irq_clr),
        .cmd_size(cmd_size), .cmd(cmd), .cmd_we(cmd_we), .cmd_rd_en(cmd_rd_en),
        .engine_ready(engine_ready), .engine_valid(engine_valid), .engine_reset(engine_reset),
        .op_type(op_type), .padding(padding), .stride(stride), .kernel(kernel),
        .i_channel(i_channel), .o_channel(o_channel), .i_side(i_side), .o_side(o_side),
        .kernel_size(kernel_size), .stride2(stride2),
        .weight_start_addr(weight_start_addr), .data_start_addr(data_start_addr),
        .result_start_addr(result_start_addr), .done_cmd_count(done_cmd_count),
        .busy(busy), .err(err), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag,
                              input logic [31:0] e_op, input logic [31:0] e_pad,
                              input logic [31:0] e_str, input logic [31:0] e_ker,
                              input logic [31:0] e_ich, input logic [31:0] e_och,
                              input logic [31:0] e_is, input logic [31:0] e_os,
                              input logic [31:0] e_ks, input logic [31:0] e_s2,
                              input logic [31:0] e_wa, input logic [31:0] e_da,
                              input logic [31:0] e_ra);
        chk({tag, ".op_type"}, 32'(op_type), e_op);
        chk({tag, ".padding"}, 32'(padding), e_pad);
        chk({tag, ".stride"}, 32'(stride), e_str);
        chk({tag, ".kernel"}, 32'(kernel), e_ker);
        chk({tag, ".i_channel"}, 32'(i_channel), e_ich);
        chk({tag, ".o_channel"}, 32'(o_channel), e_och);
        chk({tag, ".i_side"}, 32'(i_side), e_is);
        chk({tag, ".o_side"}, 32'(o_side), e_os);
        chk({tag, ".kernel_size"}, 32'(kernel_size), e_ks);
        chk({tag, ".stride2"}, 32'(stride2), e_s2);
        chk({tag, ".weight"}, weight_start_addr, e_wa);
        chk({tag, ".data"}, data_start_addr, e_da);
        chk({tag, ".result"}, result_start_addr, e_ra);
    endtask

    task automatic fields_a(input string tag);
        chk_fields(tag, 1, 1, 1, 3, 32'h20, 32'h40, 32'h1E, 32'h1C, 9, 2,
                   32'h1000_0000, 32'h2000_0000, 32'h3000_0000);
    endtask

    task automatic fields_b(input string tag);
        chk_fields(tag, 1, 0, 2, 5, 32'h40, 32'h80, 32'h1C, 32'h0E, 3, 1,
                   32'h1100_0000, 32'h2100_0000, 32'h3100_0000);
    endtask

    // Streams six words; returns in the cycle right after word 5 was accepted.
    task automatic send_cmd(input logic [31:0] words [6], input int gap, input string tag);
        for (int i = 0; i < 6; i++) begin
            cmd    = words[i];
            cmd_we = 1'b1;
            #1;
            if (i == 0) chk({tag, ".rd_en_w0"}, 32'(cmd_rd_en), 1);
            if (i == 5) chk({tag, ".rd_en_w5"}, 32'(cmd_rd_en), 0);
            cyc();
            cmd_we = 1'b0;
            if (i < 5) repeat (gap) cyc();
        end
    endtask

    task automatic pulse_ready();
        engine_ready = 1'b1;
        cyc();
        engine_ready = 1'b0;
    endtask

    task automatic start(input int n);
        cmd_size = CNT_W'(n);
        op_en    = 1'b1;
        cyc();
        op_en    = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        cyc();
        irq_clr = 1'b0;
    endtask

    initial begin
        cmd_a = '{32'h0003_0111, 32'h0040_0020, 32'h0209_1C1E,
                  32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
        cmd_b = '{32'h0005_0201, 32'h0080_0040, 32'h0103_0E1C,
                  32'h1100_0000, 32'h2100_0000, 32'h3100_0000};
        cmd_c = '{32'h0003_0112, 32'h0040_0020, 32'h0209_1C1E,
                  32'h1200_0000, 32'h2200_0000, 32'h3200_0000};

        // Reset state
        cyc();
        cyc();
        chk("rst.engine_reset", 32'(engine_reset), 1);
        chk("rst.engine_valid", 32'(engine_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.irq", 32'(irq), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.cmd_rd_en", 32'(cmd_rd_en), 0);
        chk("rst.done", 32'(done_cmd_count), 0);
        rst_n = 1'b1;
        cyc();

        // T1: two commands, second one prefetched during RUN
        engine_ready = 1'b1;
        cyc();
        engine_ready = 1'b0;
        chk("t1.ready_idle_ignored", 32'(done_cmd_count), 0);
        start(2);
        chk("t1.busy", 32'(busy), 1);
        chk("t1.rd_en_wait", 32'(cmd_rd_en), 1);
        send_cmd(cmd_a, 0, "t1a");
        chk("t1.valid_t1", 32'(engine_valid), 0);
        chk("t1.rd_en_full", 32'(cmd_rd_en), 0);
        cyc();
        chk("t1.valid_t2", 32'(engine_valid), 0);
        cyc();
        chk("t1.valid_t3", 32'(engine_valid), 1);
        chk("t1.engine_reset_run", 32'(engine_reset), 0);
        fields_a("t1.a");
        send_cmd(cmd_b, 0, "t1b");
        fields_a("t1.a_stable");
        chk("t1.valid_during_prefetch", 32'(engine_valid), 1);
        repeat (44) cyc();
        pulse_ready();
        chk("t1.valid_after_ready", 32'(engine_valid), 0);
        chk("t1.engine_reset_gap", 32'(engine_reset), 1);
        chk("t1.done1", 32'(done_cmd_count), 1);
        cyc();
        chk("t1.valid_prefetch_t2", 32'(engine_valid), 1);
        fields_b("t1.b");
        repeat (50) cyc();
        pulse_ready();
        chk("t1.irq", 32'(irq), 1);
        chk("t1.busy_finish", 32'(busy), 0);
        chk("t1.done2", 32'(done_cmd_count), 2);
        chk("t1.valid_finish", 32'(engine_valid), 0);
        chk("t1.err", 32'(err), 0);
        chk("t1.rd_en_finish", 32'(cmd_rd_en), 0);
        clear_irq();
        chk("t1.irq_clr", 32'(irq), 0);
        chk("t1.done_clr", 32'(done_cmd_count), 0);

        // T2: empty run
        start(0);
        chk("t2.irq", 32'(irq), 1);
        chk("t2.busy", 32'(busy), 0);
        chk("t2.rd_en", 32'(cmd_rd_en), 0);
        cyc();
        chk("t2.rd_en_later", 32'(cmd_rd_en), 0);
        clear_irq();
        chk("t2.irq_clr", 32'(irq), 0);

        // T3: second command carries an invalid op_type
        start(2);
        send_cmd(cmd_a, 0, "t3a");
        cyc();
        cyc();
        chk("t3.valid_a", 32'(engine_valid), 1);
        send_cmd(cmd_c, 0, "t3c");
        repeat (10) cyc();
        pulse_ready();
        chk("t3.done1", 32'(done_cmd_count), 1);
        cyc();
        chk("t3.err", 32'(err), 1);
        chk("t3.irq", 32'(irq), 1);
        chk("t3.busy", 32'(busy), 0);
        chk("t3.engine_reset", 32'(engine_reset), 1);
        repeat (5) cyc();
        chk("t3.no_valid", 32'(engine_valid), 0);
        chk("t3.rd_en", 32'(cmd_rd_en), 0);
        fields_a("t3.fields_held");
        clear_irq();
        chk("t3.err_clr", 32'(err), 0);
        chk("t3.irq_clr", 32'(irq), 0);

        // T4: gapped words, then stray writes while the shadow is full
        start(1);
        send_cmd(cmd_a, 2, "t4");
        cmd    = 32'hFFFF_FFFF;
        cmd_we = 1'b1;
        #1;
        chk("t4.rd_en_stray", 32'(cmd_rd_en), 0);
        cyc();
        cyc();
        cmd_we = 1'b0;
        chk("t4.valid", 32'(engine_valid), 1);
        chk("t4.err", 32'(err), 0);
        fields_a("t4.a");
        pulse_ready();
        chk("t4.irq", 32'(irq), 1);
        chk("t4.done", 32'(done_cmd_count), 1);
        clear_irq();

        // T5: asynchronous reset in RUN, then a clean restart
        start(2);
        send_cmd(cmd_b, 0, "t5b");
        cyc();
        cyc();
        chk("t5.valid_pre", 32'(engine_valid), 1);
        rst_n = 1'b0;
        #2;
        chk("t5.valid_async", 32'(engine_valid), 0);
        chk("t5.engine_reset_async", 32'(engine_reset), 1);
        chk("t5.busy_async", 32'(busy), 0);
        chk("t5.op_type_async", 32'(op_type), 0);
        chk("t5.kernel_async", 32'(kernel), 0);
        chk("t5.result_async", result_start_addr, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        start(1);
        send_cmd(cmd_a, 0, "t5a");
        cyc();
        cyc();
        chk("t5.valid_restart", 32'(engine_valid), 1);
        fields_a("t5.a");
        pulse_ready();
        chk("t5.irq", 32'(irq), 1);
        chk("t5.done", 32'(done_cmd_count), 1);
        clear_irq();
        chk("t5.idle_irq", 32'(irq), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
